// File: rtl/dbg_pkg.sv
// Shared constants and state encoding for the debug bus bridge.
package dbg_pkg;

  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] RSP_K   = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h54;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    BUS_WR,
    BUS_RD,
    RESP
  } state_t;

endpackage

// File: rtl/dbg_tx_ser.sv
// Serializes a 1- or 4-byte response word onto a valid/ready byte stream, low byte first.
module dbg_tx_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [2:0]  len,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_c
);

  logic [23:0] rest;
  logic [1:0]  rem;

  assign last_c = tx_valid && tx_ready && (rem == 2'd0);

  // Byte n+1 is presented the cycle after byte n is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rest     <= 24'h0;
      rem      <= 2'd0;
    end else if (load) begin
      tx_data  <= word[7:0];
      rest     <= word[31:8];
      rem      <= 2'(len - 3'd1);
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (rem == 2'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data <= rest[7:0];
        rest    <= {8'h00, rest[23:8]};
        rem     <= rem - 2'd1;
      end
    end
  end

endmodule

// File: rtl/dbg_bridge.sv
// UART byte-command interpreter acting as a bus initiator for memory peek/poke.
module dbg_bridge
  import dbg_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [15:0]  addr,
  output logic         ren,
  input  logic [W-1:0] rdata,
  input  logic         rd_valid,
  output logic         wen,
  output logic [W-1:0] wdata,
  output logic [3:0]   wmask,
  output logic         busy
);

  localparam int unsigned TW = 8;

  state_t          state, state_n;
  logic            op_rd, op_rd_n;
  logic [7:0]      a1, a1_n;
  logic [1:0]      lane, lane_n;
  logic [31:0]     d, d_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic [15:0]     addr_n;
  logic            ren_n, wen_n, busy_n;
  logic [W-1:0]    wdata_n;
  logic [3:0]      wmask_n;
  logic            ld_c, last_c;
  logic [31:0]     ld_word_c;
  logic [2:0]      ld_len_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_rd <= 1'b0;
      a1    <= 8'h00;
      lane  <= 2'd0;
      d     <= 32'h0;
      tmo   <= '0;
      addr  <= 16'h0;
      ren   <= 1'b0;
      wen   <= 1'b0;
      wdata <= '0;
      wmask <= 4'h0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      op_rd <= op_rd_n;
      a1    <= a1_n;
      lane  <= lane_n;
      d     <= d_n;
      tmo   <= tmo_n;
      addr  <= addr_n;
      ren   <= ren_n;
      wen   <= wen_n;
      wdata <= wdata_n;
      wmask <= wmask_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_rd_n   = op_rd;
    a1_n      = a1;
    lane_n    = lane;
    d_n       = d;
    tmo_n     = tmo;
    addr_n    = addr;
    ren_n     = ren;
    wen_n     = 1'b0;
    wdata_n   = wdata;
    wmask_n   = 4'h0;
    ld_c      = 1'b0;
    ld_word_c = 32'h0;
    ld_len_c  = 3'd1;
    unique case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == CMD_W || rx_data == CMD_R) begin
          op_rd_n = (rx_data == CMD_R);
          state_n = ADDR_HI;
        end else begin
          ld_c      = 1'b1;
          ld_word_c = {24'h0, RSP_ERR};
          state_n   = RESP;
        end
      end
      ADDR_HI: if (rx_valid) begin
        a1_n    = rx_data;
        state_n = ADDR_LO;
      end
      ADDR_LO: if (rx_valid) begin
        addr_n = {a1, rx_data};
        if (op_rd) begin
          ren_n   = 1'b1;
          tmo_n   = '0;
          state_n = BUS_RD;
        end else begin
          lane_n  = 2'd0;
          state_n = DATA;
        end
      end
      // Bytes land little-endian; the 4th byte launches the write strobe.
      DATA: if (rx_valid) begin
        d_n[{lane, 3'b000} +: 8] = rx_data;
        lane_n = lane + 2'd1;
        if (lane == 2'd3) begin
          wen_n   = 1'b1;
          wmask_n = 4'hF;
          wdata_n = d_n;
          state_n = BUS_WR;
        end
      end
      BUS_WR: begin
        ld_c      = 1'b1;
        ld_word_c = {24'h0, RSP_K};
        state_n   = RESP;
      end
      BUS_RD: begin
        if (rd_valid) begin
          ren_n     = 1'b0;
          ld_c      = 1'b1;
          ld_word_c = rdata;
          ld_len_c  = 3'd4;
          state_n   = RESP;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          ren_n     = 1'b0;
          ld_c      = 1'b1;
          ld_word_c = {24'h0, RSP_TMO};
          state_n   = RESP;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      RESP: if (last_c) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  dbg_tx_ser u_tx_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld_c),
    .word     (ld_word_c),
    .len      (ld_len_c),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .last_c   (last_c)
  );

endmodule

// File: tb/tb_dbg_bridge.sv
// Self-checking bench for dbg_bridge: vector table, corner sequences and randomized commands vs a memory model.
module tb_dbg_bridge;

  localparam int unsigned TMO = 255;
  typedef logic [7:0] bq_t [$];

  typedef struct packed {
    logic [55:0] cmd;
    int          n;
    int          lat;
    bit          tmo;
    logic [31:0] rsp;
    int          nrsp;
    int          ren;
  } vec_t;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] addr;
  logic        ren, rd_valid, wen, busy;
  logic [31:0] rdata, wdata;
  logic [3:0]  wmask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dbg_bridge #(.W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .addr(addr), .ren(ren), .rdata(rdata), .rd_valid(rd_valid),
    .wen(wen), .wdata(wdata), .wmask(wmask), .busy(busy)
  );

  // Bus responder: memory answered after a programmable number of ren cycles.
  logic [31:0] smem [0:65535];
  logic [31:0] mdl  [0:65535];
  int lat;
  bit rsp_en;
  int rcnt;
  always @(posedge clk) rcnt <= ren ? rcnt + 1 : 0;
  assign rd_valid = rsp_en && ren && (rcnt == lat);
  assign rdata    = rd_valid ? smem[addr] : 32'hA5A5A5A5;

  int      n_chk, n_fail;
  longint  cyc;
  bq_t     txq;
  longint  txc [$];
  int      wen_cnt, ren_run, last_ren;
  logic    prev_v, prev_r;
  logic [7:0] prev_d;
  bit      rdy_rand;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: collects accepted bytes and bus writes, checks handshake rules.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_v  = 1'b0;
      ren_run = 0;
    end else begin
      chk("wmask_rule", 64'(wmask), wen ? 64'hF : 64'h0);
      if (prev_v && !prev_r) begin
        chk("tx_hold_valid", 64'(tx_valid), 64'd1);
        chk("tx_hold_data", 64'(tx_data), 64'(prev_d));
      end
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        txc.push_back(cyc);
      end
      if (wen) begin
        wen_cnt++;
        smem[addr] = wdata;
      end
      if (ren) ren_run++;
      else if (ren_run != 0) begin
        last_ren = ren_run;
        ren_run  = 0;
      end
      prev_v = tx_valid;
      prev_r = tx_ready;
      prev_d = tx_data;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("idle_reached", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Reference model: command bytes -> expected response bytes, tracking memory contents.
  task automatic model_cmd(input bq_t c, input bit tmo, output bq_t rsp);
    logic [15:0] a;
    rsp = {};
    if (c[0] == 8'h57) begin
      a = {c[1], c[2]};
      mdl[a] = {c[6], c[5], c[4], c[3]};
      rsp.push_back(8'h4B);
    end else if (c[0] == 8'h52) begin
      a = {c[1], c[2]};
      if (tmo) rsp.push_back(8'h54);
      else for (int i = 0; i < 4; i++) rsp.push_back(8'((mdl[a] >> (8 * i)) & 32'hFF));
    end else begin
      rsp.push_back(8'h3F);
    end
  endtask

  task automatic run_cmd(input bq_t c, input int l, input bit tmo, input bq_t exp,
                         input int exp_ren, input bit b2b, input string nm);
    bit is_wr, is_rd;
    is_wr = (c[0] == 8'h57);
    is_rd = (c[0] == 8'h52);
    lat = l; rsp_en = !tmo;
    txq = {}; txc = {}; wen_cnt = 0; last_ren = 0;
    for (int i = 0; i < c.size(); i++) send_byte(c[i]);
    if (is_wr) begin
      chk({nm, "_wen"}, 64'(wen), 64'd1);
      chk({nm, "_waddr"}, 64'(addr), 64'({c[1], c[2]}));
      chk({nm, "_wdata"}, 64'(wdata), 64'({c[6], c[5], c[4], c[3]}));
      @(posedge clk);
      #1;
      chk({nm, "_wen_off"}, 64'(wen), 64'd0);
      chk({nm, "_k_valid"}, 64'(tx_valid), 64'd1);
      chk({nm, "_k_data"}, 64'(tx_data), 64'h4B);
    end else if (is_rd) begin
      chk({nm, "_ren"}, 64'(ren), 64'd1);
      chk({nm, "_raddr"}, 64'(addr), 64'({c[1], c[2]}));
    end else begin
      chk({nm, "_err_valid"}, 64'(tx_valid), 64'd1);
      chk({nm, "_err_data"}, 64'(tx_data), 64'h3F);
    end
    wait_idle(TMO + 100);
    chk({nm, "_nbytes"}, 64'(txq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk({nm, "_byte"}, (i < txq.size()) ? 64'(txq[i]) : 64'hDEAD, 64'(exp[i]));
    chk({nm, "_ren_len"}, 64'(last_ren), 64'(exp_ren));
    chk({nm, "_wen_cnt"}, 64'(wen_cnt), is_wr ? 64'd1 : 64'd0);
    if (b2b && exp.size() == 4 && txc.size() == 4)
      chk({nm, "_b2b"}, 64'(txc[3] - txc[0]), 64'd3);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, 64'(addr), 64'd0);
    chk({nm, "_ren"}, 64'(ren), 64'd0);
    chk({nm, "_wen"}, 64'(wen), 64'd0);
    chk({nm, "_wdata"}, 64'(wdata), 64'd0);
    chk({nm, "_wmask"}, 64'(wmask), 64'd0);
    chk({nm, "_txd"}, 64'(tx_data), 64'd0);
    chk({nm, "_txv"}, 64'(tx_valid), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    bq_t  c, e, m;
    int   l, eren, k;
    bit   tmo;
    logic [15:0] a;
    logic [31:0] dw;
    bit   seen;

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    rsp_en = 1'b0; lat = 0; rdy_rand = 1'b0;
    for (int i = 0; i < 65536; i++) begin smem[i] = 32'h0; mdl[i] = 32'h0; end
    smem[16'h0004] = 32'h12345678; mdl[16'h0004] = 32'h12345678;
    smem[16'h0000] = 32'hCAFEF00D; mdl[16'h0000] = 32'hCAFEF00D;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl[0] = '{{8'h57, 8'h80, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 7, 0, 1'b0, 32'h4B000000, 1, 0};
    tbl[1] = '{{8'h52, 8'h00, 8'h04, 32'h0}, 3, 1, 1'b0, 32'h78563412, 4, 2};
    tbl[2] = '{{8'h52, 8'h40, 8'h00, 32'h0}, 3, 0, 1'b1, 32'h54000000, 1, 255};
    tbl[3] = '{{8'h41, 48'h0}, 1, 0, 1'b0, 32'h3F000000, 1, 0};
    tbl[4] = '{{8'h52, 8'h00, 8'h00, 32'h0}, 3, 0, 1'b0, 32'h0DF0FECA, 4, 1};
    tbl[5] = '{{8'h52, 8'h80, 8'h10, 32'h0}, 3, 2, 1'b0, 32'hEFBEADDE, 4, 3};
    tbl[6] = '{{8'h57, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04}, 7, 0, 1'b0, 32'h4B000000, 1, 0};
    tbl[7] = '{{8'h52, 8'hFF, 8'hFF, 32'h0}, 3, 3, 1'b0, 32'h01020304, 4, 4};
    tbl[8] = '{{8'h00, 48'h0}, 1, 0, 1'b0, 32'h3F000000, 1, 0};
    tbl[9] = '{{8'hFF, 48'h0}, 1, 0, 1'b0, 32'h3F000000, 1, 0};

    for (int v = 0; v < 10; v++) begin
      c = {}; e = {};
      for (int i = 0; i < tbl[v].n; i++) c.push_back(tbl[v].cmd[55 - 8 * i -: 8]);
      for (int i = 0; i < tbl[v].nrsp; i++) e.push_back(tbl[v].rsp[31 - 8 * i -: 8]);
      model_cmd(c, tbl[v].tmo, m);
      run_cmd(c, tbl[v].lat, tbl[v].tmo, e, tbl[v].ren, 1'b1, $sformatf("vec%0d", v));
    end

    // rx byte coinciding with the last response acceptance must be dropped.
    txq = {};
    send_byte(8'h41);
    chk("drop_txv", 64'(tx_valid), 64'd1);
    chk("drop_txd", 64'(tx_data), 64'h3F);
    send_byte(8'h52);
    wait_idle(50);
    chk("drop_nbytes", 64'(txq.size()), 64'd1);
    chk("drop_busy", 64'(busy), 64'd0);

    // Backpressure: 10 stalled cycles per byte, with a stray rx byte mid-response.
    lat = 1; rsp_en = 1'b1; txq = {};
    tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h04);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = tx_valid;
    end
    chk("bp_first_valid", 64'(seen), 64'd1);
    for (int b = 0; b < 4; b++) begin
      repeat (10) begin @(posedge clk); #1; end
      if (b == 2) send_byte(8'h57);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
    end
    wait_idle(20);
    tx_ready = 1'b1;
    chk("bp_nbytes", 64'(txq.size()), 64'd4);
    chk("bp_bytes", (txq.size() == 4) ? 64'({txq[0], txq[1], txq[2], txq[3]}) : 64'hDEAD,
        64'h78563412);
    c = {8'h41}; e = {8'h3F};
    run_cmd(c, 0, 1'b0, e, 0, 1'b1, "bp_after");

    // Reset in the middle of a write command.
    txq = {}; wen_cnt = 0;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h11);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_nowen", 64'(wen_cnt), 64'd0);
    chk("midrst_notx", 64'(txq.size()), 64'd0);
    c = {8'h52, 8'h00, 8'h00};
    model_cmd(c, 1'b0, e);
    run_cmd(c, 1, 1'b0, e, 2, 1'b1, "midrst_rd");

    // Randomized commands with random tx_ready against the memory model.
    rdy_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: a = 16'h0000;
        1: a = 16'h0004;
        2: a = 16'h8010;
        3: a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      tmo = 1'b0; l = 0; eren = 0;
      if (k < 4) begin
        dw = $urandom;
        c = {8'h57, a[15:8], a[7:0], dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
      end else if (k < 8) begin
        l = $urandom_range(0, 3);
        eren = l + 1;
        c = {8'h52, a[15:8], a[7:0]};
      end else if (k == 8) begin
        c = {8'h00};
        do c[0] = 8'($urandom); while (c[0] == 8'h52 || c[0] == 8'h57);
      end else begin
        tmo = 1'b1;
        eren = TMO;
        c = {8'h52, a[15:8], a[7:0]};
      end
      model_cmd(c, tmo, e);
      run_cmd(c, l, tmo, e, eren, 1'b0, "rnd");
    end
    rdy_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
